alu_ctrl_seq: RTL and testbench

- Parametrised, registered successor to the combinational ALU control decoder in the MIPS datapath; sits between the main control unit and the ALU/mult-div unit.
- Maps aluOp plus funct to an ALU function code with one cycle of registered latency and a valid/stall/flush handshake.
- Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU: starts the mult-div unit, counts its latency and holds the pipeline off until completion.

---
 rtl/alu_ctrl_pkg.sv | 52 +++++
 rtl/alu_ctrl_seq_if.sv | 31 +++
 rtl/alu_ctrl_decode.sv | 55 +++++
 rtl/alu_ctrl_seq.sv | 155 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the registered ALU control decoder and its mult-div sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: aluOp class codes, ALU function codes, mult-div funct codes, md_op encoding, FSM states.
package alu_ctrl_pkg;

    // aluOp classes issued by the main control unit
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_CLX   = 4'b0001;
    localparam logic [3:0] OP_LWSW  = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDIU = 4'b0100;
    localparam logic [3:0] OP_LBU   = 4'b0101;
    localparam logic [3:0] OP_BGTZ  = 4'b0110;
    localparam logic [3:0] OP_SB    = 4'b0111;
    localparam logic [3:0] OP_B     = 4'b1000;

    // ALU function codes driven towards the ALU
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_ADDU = 6'b100001;
    localparam logic [5:0] ALU_SUB  = 6'b100010;
    localparam logic [5:0] ALU_SLT  = 6'b101010;
    localparam logic [5:0] ALU_CLO  = 6'b111000;
    localparam logic [5:0] ALU_CLZ  = 6'b000111;

    // SPECIAL2 funct fields that select count-leading ones/zeros
    localparam logic [5:0] FN_CLO = 6'b100001;
    localparam logic [5:0] FN_CLZ = 6'b100000;

    // Multi-cycle funct fields handled by the mult-div unit
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Handshake/bus bundle between main control, the ALU control sequencer and the ALU/mult-div side.
// Latency: n/a (wiring only).
// Backpressure: stall holds outputs, stall_req tells upstream to hold valid_in.
// master: upstream control (drives valid_in/aluOp/funcIn/stall/flush); slave: alu_ctrl_seq.
interface alu_ctrl_seq_if #(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6
);
    logic              valid_in;
    logic [OP_W-1:0]   aluOp;
    logic [FUNC_W-1:0] funcIn;
    logic              stall;
    logic              flush;
    logic [FUNC_W-1:0] alu_func;
    logic              valid_out;
    logic              stall_req;
    logic              md_start;
    logic [1:0]        md_op;
    logic              md_done;
    logic              illegal;

    modport master (
        output valid_in, aluOp, funcIn, stall, flush,
        input  alu_func, valid_out, stall_req, md_start, md_op, md_done, illegal
    );

    modport slave (
        input  valid_in, aluOp, funcIn, stall, flush,
        output alu_func, valid_out, stall_req, md_start, md_op, md_done, illegal
    );
endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational aluOp/funct -> ALU function code table with mult-div and illegal-op detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is used.
// Ports: aluOp, funcIn in; code, is_md, md_op, is_illegal out.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 6
) (
    input  logic [OP_W-1:0]   aluOp,
    input  logic [FUNC_W-1:0] funcIn,
    output logic [FUNC_W-1:0] code,
    output logic              is_md,
    output md_op_t            md_op,
    output logic              is_illegal
);

    always_comb begin
        code       = funcIn;
        is_illegal = 1'b0;
        case (aluOp)
            OP_W'(OP_RTYPE): code = funcIn;
            OP_W'(OP_CLX): begin
                // Only the two SPECIAL2 counts are remapped; anything else passes through
                if (funcIn == FUNC_W'(FN_CLO))      code = FUNC_W'(ALU_CLO);
                else if (funcIn == FUNC_W'(FN_CLZ)) code = FUNC_W'(ALU_CLZ);
                else                                code = funcIn;
            end
            OP_W'(OP_LWSW), OP_W'(OP_LBU), OP_W'(OP_SB): code = FUNC_W'(ALU_ADD);
            OP_W'(OP_BEQ), OP_W'(OP_B):                  code = FUNC_W'(ALU_SUB);
            OP_W'(OP_ADDIU):                             code = FUNC_W'(ALU_ADDU);
            OP_W'(OP_BGTZ):                              code = FUNC_W'(ALU_SLT);
            default: begin
                code       = funcIn;
                is_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        is_md = 1'b0;
        md_op = MD_MULT;
        if (aluOp == OP_W'(OP_RTYPE)) begin
            case (funcIn)
                FUNC_W'(FN_MULT):  begin is_md = 1'b1; md_op = MD_MULT;  end
                FUNC_W'(FN_MULTU): begin is_md = 1'b1; md_op = MD_MULTU; end
                FUNC_W'(FN_DIV):   begin is_md = 1'b1; md_op = MD_DIV;   end
                FUNC_W'(FN_DIVU):  begin is_md = 1'b1; md_op = MD_DIVU;  end
                default:           begin is_md = 1'b0; md_op = MD_MULT;  end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with a sequencer that starts and waits out multi-cycle MULT/DIV ops.
// Latency: 1 cycle for single-cycle ops; MUL_LAT / DIV_LAT edges (plus any stall) for mult-div ops.
// Backpressure: stall holds alu_func/valid_out; stall_req is high while a mult-div op is in flight.
// Ports: clk, rst_n (async active-low), bus (alu_ctrl_seq_if.slave).
// Build option: define ALU_CTRL_ILLEGAL_TRAP_EN for a sticky illegal-aluOp flag; otherwise illegal is 0.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int FUNC_W  = 6,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_seq_if.slave bus
);

    localparam int CNT_W = $clog2(maxInt(MUL_LAT, DIV_LAT)) + 1;

    logic [FUNC_W-1:0] decCode;
    logic              decIsMd;
    md_op_t            decMdOp;
    logic              decIllegal;

    alu_ctrl_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W)
    ) u_decode (
        .aluOp      (bus.aluOp),
        .funcIn     (bus.funcIn),
        .code       (decCode),
        .is_md      (decIsMd),
        .md_op      (decMdOp),
        .is_illegal (decIllegal)
    );

    state_t            stateQ, stateD;
    logic [CNT_W-1:0]  cntQ, cntD;
    logic [FUNC_W-1:0] aluFuncQ, aluFuncD;
    logic              validOutQ, validOutD;
    logic              stallReqQ, stallReqD;
    logic              mdStartQ, mdStartD;
    md_op_t            mdOpQ, mdOpD;
    logic              mdDoneQ, mdDoneD;
    logic              accept;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegalQ, illegalD;
`else
    logic unusedIllegal;
    assign unusedIllegal = decIllegal;
`endif

    assign accept = bus.valid_in && !bus.stall && !stallReqQ && !bus.flush;

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        aluFuncD  = aluFuncQ;
        validOutD = validOutQ;
        stallReqD = stallReqQ;
        mdStartD  = 1'b0;
        mdOpD     = mdOpQ;
        mdDoneD   = 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegalD  = illegalQ;
`endif
        if (bus.flush) begin
            // Flush wins over everything, including a completing mult-div op
            validOutD = 1'b0;
            if (stateQ == MD_BUSY) begin
                stateD    = IDLE;
                stallReqD = 1'b0;
                cntD      = '0;
            end
        end else begin
            case (stateQ)
                IDLE: begin
                    if (accept) begin
                        aluFuncD = decIsMd ? bus.funcIn : decCode;
                        if (decIsMd) begin
                            // Result is not valid until the mult-div unit finishes
                            validOutD = 1'b0;
                            mdStartD  = 1'b1;
                            mdOpD     = decMdOp;
                            stallReqD = 1'b1;
                            stateD    = MD_BUSY;
                            cntD      = decMdOp[1] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                        end else begin
                            validOutD = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                            if (decIllegal) illegalD = 1'b1;
`endif
                        end
                    end else if (!bus.stall) begin
                        validOutD = 1'b0;
                    end
                end
                MD_BUSY: begin
                    // The unit keeps computing under stall; only completion waits for it
                    if (cntQ != '0) begin
                        cntD = cntQ - CNT_W'(1);
                    end else if (!bus.stall) begin
                        stateD    = IDLE;
                        validOutD = 1'b1;
                        mdDoneD   = 1'b1;
                        stallReqD = 1'b0;
                    end
                end
                default: stateD = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= IDLE;
            cntQ      <= '0;
            aluFuncQ  <= '0;
            validOutQ <= 1'b0;
            stallReqQ <= 1'b0;
            mdStartQ  <= 1'b0;
            mdOpQ     <= MD_MULT;
            mdDoneQ   <= 1'b0;
        end else begin
            stateQ    <= stateD;
            cntQ      <= cntD;
            aluFuncQ  <= aluFuncD;
            validOutQ <= validOutD;
            stallReqQ <= stallReqD;
            mdStartQ  <= mdStartD;
            mdOpQ     <= mdOpD;
            mdDoneQ   <= mdDoneD;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegalQ <= 1'b0;
        else        illegalQ <= illegalD;
    end
    assign bus.illegal = illegalQ;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.alu_func  = aluFuncQ;
    assign bus.valid_out = validOutQ;
    assign bus.stall_req = stallReqQ;
    assign bus.md_start  = mdStartQ;
    assign bus.md_op     = mdOpQ;
    assign bus.md_done   = mdDoneQ;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a.
// Backpressure: exercises stall, flush and stall_req holding.
module tb_alu_ctrl_seq;
    localparam int OP_W    = 4;
    localparam int FUNC_W  = 6;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_ctrl_seq_if #(.OP_W(OP_W), .FUNC_W(FUNC_W)) bus ();

    alu_ctrl_seq #(
        .OP_W    (OP_W),
        .FUNC_W  (FUNC_W),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the outputs should be after the latest edge
    logic [5:0] mAlu;
    logic       mValid, mActive, mStart, mDone, mIll;
    logic [1:0] mOp;
    int         mElapsed, mLat;

    function automatic logic [6:0] refDecode(input logic [3:0] op, input logic [5:0] fn);
        case (op)
            4'd0:             return {1'b0, fn};
            4'd1:             return (fn == 6'b100001) ? 7'b0111000 :
                                     (fn == 6'b100000) ? 7'b0000111 : {1'b0, fn};
            4'd2, 4'd5, 4'd7: return 7'b0100000;
            4'd3, 4'd8:       return 7'b0100010;
            4'd4:             return 7'b0100001;
            4'd6:             return 7'b0101010;
            default:          return {1'b1, fn};
        endcase
    endfunction

    function automatic logic [12:0] dutVec();
        return {bus.alu_func, bus.valid_out, bus.stall_req, bus.md_start, bus.md_op, bus.md_done, bus.illegal};
    endfunction

    function automatic logic [12:0] modelVec();
        return {mAlu, mValid, mActive, mStart, mOp, mDone, mIll};
    endfunction

    task automatic model_reset();
        mAlu = '0; mValid = 0; mActive = 0; mStart = 0; mDone = 0; mIll = 0; mOp = '0;
        mElapsed = 0; mLat = 0;
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, leave time at edge+1
    task automatic step(input logic vi, input logic [3:0] op, input logic [5:0] fn,
                        input logic st, input logic fl);
        logic [6:0] d;
        logic       isMd;
        bus.valid_in = vi; bus.aluOp = op; bus.funcIn = fn; bus.stall = st; bus.flush = fl;
        @(posedge clk);
        d    = refDecode(op, fn);
        isMd = (op == 4'd0) && (fn >= 6'd24) && (fn <= 6'd27);
        mStart = 0;
        mDone  = 0;
        if (fl) begin
            mValid  = 0;
            mActive = 0;
        end else if (mActive) begin
            mElapsed++;
            if (mElapsed >= mLat && !st) begin
                mActive = 0; mValid = 1; mDone = 1;
            end
        end else if (vi && !st) begin
            if (isMd) begin
                mAlu = fn; mValid = 0; mStart = 1; mOp = fn[1:0]; mActive = 1;
                mElapsed = 0; mLat = fn[1] ? DIV_LAT : MUL_LAT;
            end else begin
                mAlu = d[5:0]; mValid = 1;
                if (d[6] && TRAP) mIll = 1;
            end
        end else if (!st) begin
            mValid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.valid_in = 0; bus.aluOp = '0; bus.funcIn = '0; bus.stall = 0; bus.flush = 0;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        checks++;
        if (dutVec() !== 13'b0) begin
            errors++; $display("FAIL reset_values got %b exp %b", dutVec(), 13'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(0, 4'd0, 6'd0, 0, 0);
        checks++;
        if (dutVec() !== modelVec()) begin
            errors++; $display("FAIL reset_idle got %b exp %b", dutVec(), modelVec());
        end
    endtask

    task automatic test_clo_clz();
        step(1, 4'd1, 6'b100001, 0, 0);
        checks++;
        if ({bus.alu_func, bus.valid_out} !== {6'b111000, 1'b1}) begin
            errors++; $display("FAIL clo got %b/%b exp 111000/1", bus.alu_func, bus.valid_out);
        end
        step(1, 4'd1, 6'b100000, 0, 0);
        checks++;
        if ({bus.alu_func, bus.valid_out} !== {6'b000111, 1'b1}) begin
            errors++; $display("FAIL clz got %b/%b exp 000111/1", bus.alu_func, bus.valid_out);
        end
        step(1, 4'd1, 6'b101010, 0, 0);
        checks++;
        if (bus.alu_func !== 6'b101010) begin
            errors++; $display("FAIL clx_passthru got %b exp 101010", bus.alu_func);
        end
        step(0, 4'd0, 6'd0, 0, 0);
        checks++;
        if (dutVec() !== modelVec()) begin
            errors++; $display("FAIL clx_idle got %b exp %b", dutVec(), modelVec());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [3];
        logic [5:0] exp [3];
        ops = '{4'd2, 4'd3, 4'd6};
        exp = '{6'b100000, 6'b100010, 6'b101010};
        for (int i = 0; i < 3; i++) begin
            step(1, ops[i], 6'($urandom_range(0, 63)), 0, 0);
            checks++;
            if ({bus.alu_func, bus.valid_out} !== {exp[i], 1'b1}) begin
                errors++; $display("FAIL b2b_%0d got %b/%b exp %b/1", i, bus.alu_func, bus.valid_out, exp[i]);
            end
        end
    endtask

    task automatic test_div_latency();
        step(1, 4'd0, 6'b011010, 0, 0);
        checks++;
        if ({bus.md_start, bus.md_op, bus.stall_req, bus.valid_out, bus.alu_func} !== {1'b1, 2'b10, 1'b1, 1'b0, 6'b011010}) begin
            errors++; $display("FAIL div_start got start=%b op=%b sreq=%b vo=%b", bus.md_start, bus.md_op, bus.stall_req, bus.valid_out);
        end
        // Upstream keeps offering ops while busy; they must be ignored
        for (int e = 1; e <= DIV_LAT; e++) begin
            step(1, 4'($urandom_range(2, 8)), 6'($urandom_range(0, 63)), 0, 0);
            if (e < DIV_LAT) begin
                checks++;
                if ({bus.stall_req, bus.valid_out, bus.md_done, bus.md_start} !== 4'b1000) begin
                    errors++; $display("FAIL div_busy_e%0d got sreq/vo/done/start=%b exp 1000", e,
                        {bus.stall_req, bus.valid_out, bus.md_done, bus.md_start});
                end
            end else begin
                checks++;
                if ({bus.stall_req, bus.valid_out, bus.md_done, bus.alu_func} !== {3'b011, 6'b011010}) begin
                    errors++; $display("FAIL div_done got sreq/vo/done=%b alu=%b exp 011/011010",
                        {bus.stall_req, bus.valid_out, bus.md_done}, bus.alu_func);
                end
            end
        end
        step(0, 4'd0, 6'd0, 0, 0);
        checks++;
        if (dutVec() !== modelVec()) begin
            errors++; $display("FAIL div_after got %b exp %b", dutVec(), modelVec());
        end
    endtask

    task automatic test_mult_stall();
        step(1, 4'd0, 6'b011000, 0, 0);
        for (int c = 2; c <= 8; c++) begin
            step(0, 4'd0, 6'd0, (c <= 7), 0);
            checks++;
            if (bus.md_done !== (c == 8) || bus.valid_out !== (c == 8)) begin
                errors++; $display("FAIL mult_stall_c%0d got done=%b vo=%b exp %b", c, bus.md_done, bus.valid_out, (c == 8));
            end
        end
        checks++;
        if (dutVec() !== modelVec()) begin
            errors++; $display("FAIL mult_stall_model got %b exp %b", dutVec(), modelVec());
        end
    endtask

    task automatic test_div_flush();
        step(1, 4'd0, 6'b011011, 0, 0);
        for (int c = 2; c <= 4; c++) step(0, 4'd0, 6'd0, 0, 0);
        step(1, 4'd2, 6'd0, 0, 1);
        checks++;
        if ({bus.stall_req, bus.valid_out, bus.md_done} !== 3'b000) begin
            errors++; $display("FAIL div_flush got sreq/vo/done=%b exp 000", {bus.stall_req, bus.valid_out, bus.md_done});
        end
        step(1, 4'd4, 6'd0, 0, 0);
        checks++;
        if ({bus.alu_func, bus.valid_out, bus.stall_req} !== {6'b100001, 2'b10}) begin
            errors++; $display("FAIL flush_next got alu=%b vo=%b sreq=%b exp 100001/1/0", bus.alu_func, bus.valid_out, bus.stall_req);
        end
        for (int c = 0; c < DIV_LAT + 2; c++) begin
            step(0, 4'd0, 6'd0, 0, 0);
            checks++;
            if (bus.md_done !== 1'b0) begin
                errors++; $display("FAIL flush_no_done c%0d got %b exp 0", c, bus.md_done);
            end
        end
    endtask

    task automatic test_illegal();
        step(1, 4'd15, 6'b101010, 0, 0);
        checks++;
        if ({bus.alu_func, bus.valid_out, bus.illegal} !== {6'b101010, 1'b1, TRAP}) begin
            errors++; $display("FAIL illegal_set got alu=%b vo=%b ill=%b exp 101010/1/%b", bus.alu_func, bus.valid_out, bus.illegal, TRAP);
        end
        step(1, 4'd2, 6'd0, 0, 0);
        step(0, 4'd0, 6'd0, 0, 0);
        checks++;
        if (bus.illegal !== TRAP) begin
            errors++; $display("FAIL illegal_sticky got %b exp %b", bus.illegal, TRAP);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear got %b exp 0", bus.illegal);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_async_reset();
        step(1, 4'd0, 6'b011010, 0, 0);
        step(0, 4'd0, 6'd0, 0, 0);
        step(0, 4'd0, 6'd0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dutVec() !== 13'b0) begin
            errors++; $display("FAIL async_reset got %b exp 0", dutVec());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < DIV_LAT + 2; c++) begin
            step(0, 4'd0, 6'd0, 0, 0);
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++; $display("FAIL async_reset_after c%0d got %b exp %b", c, dutVec(), modelVec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [5:0] fn;
        for (int c = 0; c < 600; c++) begin
            op = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            fn = (op == 4'd0 && $urandom_range(0, 1) == 1) ? 6'($urandom_range(24, 27)) : 6'($urandom_range(0, 63));
            if (op == 4'd1 && $urandom_range(0, 1) == 1) fn = 6'($urandom_range(32, 33));
            step(($urandom_range(0, 99) < 70), op, fn, ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 4));
            checks++;
            if (dutVec() !== modelVec()) begin
                errors++; $display("FAIL random_c%0d got %b exp %b", c, dutVec(), modelVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clo_clz();
        test_back_to_back();
        test_div_latency();
        test_mult_stall();
        test_div_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
